// File: rtl/eth_pkg.sv
// Shared Ethernet/UDP definitions used by the receive-side datapath blocks.
package eth_pkg;

  localparam int eth_udp_length_width = 16;

  typedef logic [eth_udp_length_width-1:0] eth_udp_length_t;

endpackage

// File: rtl/udp_to_axi.sv
// Packs a UDP payload byte stream little-endian into AXI-stream words with keep/last.
// Optional length checking is built only when UDP_TO_AXI_LENGTH_CHECK_EN is defined.
module udp_to_axi
  import eth_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                            Clk,
  input  logic                            Rst_n,
  input  logic [7:0]                      Udp_data,
  input  logic                            Udp_valid,
  input  logic                            Udp_last,
  input  logic [eth_udp_length_width-1:0] Udp_length,
  output logic                            Udp_ready,
  output logic                            M_axis_valid,
  output logic [AXI_DATA_WIDTH-1:0]       M_axis_data,
  output logic [AXI_DATA_WIDTH/8-1:0]     M_axis_keep,
  output logic                            M_axis_last,
  input  logic                            M_axis_ready
`ifdef UDP_TO_AXI_LENGTH_CHECK_EN
  ,
  output logic                            Length_error
`endif
);

  localparam int BPW   = AXI_DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(BPW);

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [BPW-1:0]            keep;
    logic                      last;
  } udp_to_axi_word_t;

  logic [(BPW-1)*8-1:0] acc_r;
  logic [IDX_W-1:0]     idx_r;
  udp_to_axi_word_t     out_r;
  logic                 out_valid_r;

  logic                      accept_s;
  logic                      word_done_s;
  logic [AXI_DATA_WIDTH-1:0] word_data_s;
  logic [BPW-1:0]            word_keep_s;
  udp_to_axi_word_t          word_s;

  // The output register can take a new word whenever it is empty or draining this edge.
  assign Udp_ready   = Rst_n && (!out_valid_r || M_axis_ready);
  assign accept_s    = Udp_valid && Udp_ready;
  assign word_done_s = accept_s && ((idx_r == IDX_W'(BPW - 1)) || Udp_last);

  // Lanes below idx come from the accumulator, lane idx is the incoming byte, the rest are zero.
  for (genvar j = 0; j < BPW - 1; j++) begin : g_lane
    assign word_data_s[j*8 +: 8] = (idx_r == IDX_W'(j)) ? Udp_data :
                                   ((idx_r > IDX_W'(j)) ? acc_r[j*8 +: 8] : 8'h00);
  end
  assign word_data_s[(BPW-1)*8 +: 8] = (idx_r == IDX_W'(BPW - 1)) ? Udp_data : 8'h00;

  for (genvar j = 0; j < BPW; j++) begin : g_keep
    assign word_keep_s[j] = (IDX_W'(j) <= idx_r);
  end

  // Assemble the candidate output word from the lane and keep vectors.
  always_comb begin
    word_s      = '0;
    word_s.data = word_data_s;
    word_s.keep = word_keep_s;
    word_s.last = Udp_last;
  end

  // Byte accumulator, lane index and output register.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      acc_r       <= '0;
      idx_r       <= '0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        if (word_done_s) begin
          idx_r <= '0;
        end else begin
          idx_r <= idx_r + IDX_W'(1);
          for (int j = 0; j < BPW - 1; j++) begin
            if (idx_r == IDX_W'(j)) begin
              acc_r[j*8 +: 8] <= Udp_data;
            end
          end
        end
      end
      // A reload on the handshake edge keeps valid high for back-to-back words.
      if (word_done_s) begin
        out_r       <= word_s;
        out_valid_r <= 1'b1;
      end else if (M_axis_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign M_axis_valid = out_valid_r;
  assign M_axis_data  = out_r.data;
  assign M_axis_keep  = out_r.keep;
  assign M_axis_last  = out_r.last;

`ifdef UDP_TO_AXI_LENGTH_CHECK_EN
  logic [15:0]                     cnt_r;
  logic [eth_udp_length_width-1:0] len_r;
  logic                            start_r;
  logic                            len_err_r;
  logic [15:0]                     cnt_eff_s;
  logic [eth_udp_length_width-1:0] len_eff_s;
  logic [16:0]                     cnt_inc_s;

  // At packet start the count restarts and the live Udp_length is the reference.
  always_comb begin
    cnt_eff_s = 16'h0000;
    len_eff_s = '0;
    if (start_r) begin
      cnt_eff_s = 16'h0000;
      len_eff_s = Udp_length;
    end else begin
      cnt_eff_s = cnt_r;
      len_eff_s = len_r;
    end
    cnt_inc_s = {1'b0, cnt_eff_s} + 17'd1;
  end

  // Per-packet byte counter with saturation and a one-cycle mismatch pulse.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt_r     <= 16'h0000;
      len_r     <= '0;
      start_r   <= 1'b1;
      len_err_r <= 1'b0;
    end else begin
      len_err_r <= accept_s && Udp_last && (cnt_inc_s != 17'(len_eff_s));
      if (accept_s) begin
        if (Udp_last) begin
          start_r <= 1'b1;
          cnt_r   <= 16'h0000;
        end else begin
          start_r <= 1'b0;
          len_r   <= len_eff_s;
          cnt_r   <= cnt_inc_s[16] ? 16'hFFFF : cnt_inc_s[15:0];
        end
      end
    end
  end

  assign Length_error = len_err_r;
`else
  logic unused_len_s;
  assign unused_len_s = ^Udp_length;
`endif

endmodule

// File: tb/tb_udp_to_axi.sv
// Directed and random scoreboard bench for udp_to_axi at AXI_DATA_WIDTH=32.
module tb_udp_to_axi;

  localparam int W   = 32;
  localparam int BPW = W / 8;

  typedef struct packed {
    logic [W-1:0]   data;
    logic [BPW-1:0] keep;
    logic           last;
  } word_t;

  logic           Clk;
  logic           Rst_n;
  logic [7:0]     Udp_data;
  logic           Udp_valid;
  logic           Udp_last;
  logic [15:0]    Udp_length;
  logic           Udp_ready;
  logic           M_axis_valid;
  logic [W-1:0]   M_axis_data;
  logic [BPW-1:0] M_axis_keep;
  logic           M_axis_last;
  logic           M_axis_ready;
`ifdef UDP_TO_AXI_LENGTH_CHECK_EN
  logic           Length_error;
  int             lerr_seen = 0;
  int             lerr_exp  = 0;
`endif

  udp_to_axi #(.AXI_DATA_WIDTH(W)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Udp_data(Udp_data), .Udp_valid(Udp_valid), .Udp_last(Udp_last),
    .Udp_length(Udp_length), .Udp_ready(Udp_ready),
    .M_axis_valid(M_axis_valid), .M_axis_data(M_axis_data),
    .M_axis_keep(M_axis_keep), .M_axis_last(M_axis_last),
    .M_axis_ready(M_axis_ready)
`ifdef UDP_TO_AXI_LENGTH_CHECK_EN
    , .Length_error(Length_error)
`endif
  );

  int    compared   = 0;
  int    mismatched = 0;
  int    ready_mode = 1;
  int    lasts_seen = 0;
  int    exp_lasts  = 0;
  word_t exp_q[$];
  word_t last_exp;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Downstream ready: 0 = held low, 1 = held high, 2 = random 80%
  initial begin
    M_axis_ready = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      if (ready_mode == 2) M_axis_ready = ($urandom_range(0, 99) < 80);
      else                 M_axis_ready = (ready_mode == 1);
    end
  end

  // Output monitor: pop and compare on every handshake
  initial begin
    word_t e;
    word_t o;
    forever begin
      @(negedge Clk);
`ifdef UDP_TO_AXI_LENGTH_CHECK_EN
      if (Length_error === 1'b1) lerr_seen++;
`endif
      if (Rst_n && M_axis_valid && M_axis_ready) begin
        o = '{data: M_axis_data, keep: M_axis_keep, last: M_axis_last};
        compared++;
        assert (exp_q.size() > 0) else begin
          mismatched++;
          $error("FAIL unexpected_word: got %h/%h/%b, expected no word", o.data, o.keep, o.last);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          compared++;
          assert (o === e) else begin
            mismatched++;
            $error("FAIL word: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                   o.data, o.keep, o.last, e.data, e.keep, e.last);
          end
        end
        if (M_axis_last) lasts_seen++;
      end
    end
  end

  function automatic void push_packet(input logic [7:0] q[$]);
    word_t e;
    for (int w = 0; w < q.size(); w += BPW) begin
      e = '0;
      for (int j = 0; j < BPW && (w + j) < q.size(); j++) begin
        e.data[j*8 +: 8] = q[w+j];
        e.keep[j]        = 1'b1;
      end
      e.last = ((w + BPW) >= q.size());
      if (e.last) exp_lasts++;
      exp_q.push_back(e);
      last_exp = e;
    end
  endfunction

  task automatic send_bytes(input logic [7:0] q[$], input bit end_pkt, input logic [15:0] len,
                            input int gap_pct, input bit exp_lerr);
    bit acc;
    bit all_acc;
    word_t o;
    all_acc = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        Udp_valid = 1'b0;
        Udp_data  = 8'($urandom);
        @(posedge Clk);
        #1;
      end
      Udp_valid  = 1'b1;
      Udp_data   = q[i];
      Udp_last   = end_pkt && (i == q.size() - 1);
      Udp_length = (i == 0) ? len : 16'($urandom);
      acc = 1'b0;
      for (int t = 0; t < 4000 && !acc; t++) begin
        @(negedge Clk);
        acc = Udp_ready;
        @(posedge Clk);
        #1;
      end
      if (!acc) all_acc = 1'b0;
    end
    Udp_valid = 1'b0;
    Udp_last  = 1'b0;
    Udp_data  = 8'($urandom);
    compared++;
    assert (all_acc === 1'b1) else begin
      mismatched++;
      $error("FAIL byte_accept_timeout: got %b, expected 1", all_acc);
    end
    if (end_pkt) begin
      o = '{data: M_axis_data, keep: M_axis_keep, last: M_axis_last};
      compared++;
      assert ({M_axis_valid, o} === {1'b1, last_exp}) else begin
        mismatched++;
        $error("FAIL final_word_latency: got v=%b %h/%h/%b, expected v=1 %h/%h/%b",
               M_axis_valid, o.data, o.keep, o.last, last_exp.data, last_exp.keep, last_exp.last);
      end
`ifdef UDP_TO_AXI_LENGTH_CHECK_EN
      if (exp_lerr) lerr_exp++;
      compared++;
      assert (Length_error === exp_lerr) else begin
        mismatched++;
        $error("FAIL length_error: got %b, expected %b", Length_error, exp_lerr);
      end
`endif
    end
  endtask

  initial begin
    logic [7:0] q[$];
    word_t      e;
    bit         done;
    int         n;

    Rst_n = 1'b0; Udp_valid = 1'b0; Udp_last = 1'b0; Udp_data = 8'h5A; Udp_length = 16'd0;
    repeat (3) @(posedge Clk);
    #1;
    compared++;
    assert ({Udp_ready, M_axis_valid, M_axis_data, M_axis_keep, M_axis_last} === {1'b0, 1'b0, 32'h0, 4'h0, 1'b0})
      else begin
        mismatched++;
        $error("FAIL reset_state: got rdy=%b v=%b %h/%h/%b, expected all zero",
               Udp_ready, M_axis_valid, M_axis_data, M_axis_keep, M_axis_last);
      end
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // Bytes 01..08 with ready held high
    q = {};
    for (int i = 1; i <= 8; i++) q.push_back(8'(i));
    push_packet(q);
    send_bytes(q, 1'b1, 16'd8, 0, 1'b0);

    q = {8'hAA, 8'hBB, 8'hCC};
    push_packet(q);
    send_bytes(q, 1'b1, 16'd3, 0, 1'b0);

    q = {8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    push_packet(q);
    send_bytes(q, 1'b1, 16'd5, 0, 1'b0);

    q = {8'h9E};
    push_packet(q);
    send_bytes(q, 1'b1, 16'd1, 0, 1'b0);

    // Downstream stall mid-packet
    ready_mode = 0;
    @(posedge Clk);
    #1;
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'h30 + 8'(i));
    push_packet(q);
    done = 1'b0;
    fork
      begin
        send_bytes(q, 1'b1, 16'd8, 0, 1'b0);
        done = 1'b1;
      end
    join_none
    n = 0;
    while (!M_axis_valid && n < 50) begin
      @(negedge Clk);
      n++;
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      compared++;
      assert ({M_axis_valid, M_axis_data, M_axis_keep, M_axis_last, Udp_ready} === {1'b1, 32'h33323130, 4'hF, 1'b0, 1'b0})
        else begin
          mismatched++;
          $error("FAIL stall_hold: got v=%b %h/%h/%b rdy=%b, expected v=1 33323130/f/0 rdy=0",
                 M_axis_valid, M_axis_data, M_axis_keep, M_axis_last, Udp_ready);
        end
    end
    ready_mode = 1;
    n = 0;
    while (!done && n < 200) begin
      @(posedge Clk);
      n++;
    end
    #1;

    // Reset after 6 bytes of a 12-byte packet; the first full word leaves before reset
    q = {};
    for (int i = 0; i < 6; i++) q.push_back(8'hA0 + 8'(i));
    e = '{data: 32'hA3A2A1A0, keep: 4'hF, last: 1'b0};
    exp_q.push_back(e);
    send_bytes(q, 1'b0, 16'd12, 0, 1'b0);
    Rst_n = 1'b0;
    @(posedge Clk);
    #1;
    compared++;
    assert ({Udp_ready, M_axis_valid} === 2'b00) else begin
      mismatched++;
      $error("FAIL mid_reset: got rdy=%b v=%b, expected 0 0", Udp_ready, M_axis_valid);
    end
    Rst_n = 1'b1;
    q = {8'h11, 8'h22, 8'h33, 8'h44};
    push_packet(q);
    send_bytes(q, 1'b1, 16'd4, 0, 1'b0);

`ifdef UDP_TO_AXI_LENGTH_CHECK_EN
    q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    push_packet(q);
    send_bytes(q, 1'b1, 16'd6, 0, 1'b1);
    @(posedge Clk);
    #1;
    compared++;
    assert (Length_error === 1'b0) else begin
      mismatched++;
      $error("FAIL length_error_width: got %b, expected 0", Length_error);
    end
    push_packet(q);
    send_bytes(q, 1'b1, 16'd5, 0, 1'b0);
`endif

    // Random packets, random backpressure and upstream gaps
    ready_mode = 2;
    for (int p = 0; p < 12; p++) begin
      n = $urandom_range(1, 1200);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      push_packet(q);
      send_bytes(q, 1'b1, 16'(n), 10, 1'b0);
    end

    ready_mode = 1;
    n = 0;
    while ((exp_q.size() > 0 || M_axis_valid) && n < 5000) begin
      @(posedge Clk);
      n++;
    end
    repeat (2) @(posedge Clk);
    #1;
    compared++;
    assert (exp_q.size() === 0) else begin
      mismatched++;
      $error("FAIL drain: got %0d words pending, expected 0", exp_q.size());
    end
    compared++;
    assert (lasts_seen === exp_lasts) else begin
      mismatched++;
      $error("FAIL last_count: got %0d, expected %0d", lasts_seen, exp_lasts);
    end
`ifdef UDP_TO_AXI_LENGTH_CHECK_EN
    compared++;
    assert (lerr_seen === lerr_exp) else begin
      mismatched++;
      $error("FAIL length_error_count: got %0d, expected %0d", lerr_seen, lerr_exp);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/udp_to_axi.md
Name: udp_to_axi

Overview:
- Receive-side counterpart of the AXI-to-UDP path.
- Accepts the UDP payload byte stream (data/valid/last/ready, plus the per-packet length) and packs bytes little-endian into AXI-stream words with keep and last.
- Sits between the UDP receive parser and any AXI-stream consumer; one packet in gives exactly one AXI packet out, with no gaps and no reordering.

Parameters:
- AXI_DATA_WIDTH, 32, output word width in bits; must be a multiple of 8 and at least 16. BPW = AXI_DATA_WIDTH/8.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Rst_n  in  1  synchronous active-low reset.
- Udp_data  in  8  payload byte.
- Udp_valid  in  1  byte valid.
- Udp_last  in  1  final byte of packet.
- Udp_length  in  eth_udp_length_width  packet payload length in bytes; sampled with the first byte of each packet.
- Udp_ready  out  1  byte accepted when Udp_valid && Udp_ready.
- M_axis_valid  out  1  output word valid.
- M_axis_data  out  AXI_DATA_WIDTH  packed word; byte j in bits [j*8 +: 8].
- M_axis_keep  out  BPW  byte enables; contiguous from bit 0.
- M_axis_last  out  1  final word of packet.
- M_axis_ready  in  1  downstream ready.
- Length_error  out  1  one-cycle pulse; present only with UDP_TO_AXI_LENGTH_CHECK_EN.

Behaviour:
- Interface (already decided): one clock, Clk; reset Rst_n is synchronous and active-low.
- Reset values: M_axis_valid=0, M_axis_last=0, M_axis_keep=0, M_axis_data=0, Udp_ready=0 while Rst_n=0, Length_error=0, byte index=0, accumulator cleared.
- Storage:
  - accumulator: BPW-1 bytes plus byte index 0..BPW-1;
  - output register: data/keep/last plus valid flag.
- Udp_ready = Rst_n && (!M_axis_valid || M_axis_ready). This is registered-state only; it does not depend on Udp_valid or Udp_last.
- On an accepted byte:
  - Byte is written to lane idx.
  - If idx==BPW-1 or Udp_last, the completed word (accumulated lanes plus this byte) loads the output register the same edge:
    - keep = (1<<(idx+1))-1;
    - last = Udp_last;
    - unused lanes = 0;
    - idx returns to 0.
  - Otherwise idx increments.
- Latency: the byte completing a word is accepted in cycle N; M_axis_valid is high in cycle N+1.
- Throughput: one byte per cycle while M_axis_ready is held high.
- Output hold: the output register is stable while M_axis_valid && !M_axis_ready. It clears valid on handshake unless reloaded the same edge. Simultaneous handshake and reload is legal and gives back-to-back words.
- Packet start: the first accepted byte after reset or after a last byte. A 1-byte packet produces a single word: keep=0001, last=1.
- No empty packets: Udp_last always accompanies a valid byte.
- Reset mid-packet: accumulator and output register are discarded. The next accepted byte is treated as a packet start, and no partial word is emitted.
- Udp_data is ignored when Udp_valid=0.

Optional Feature:
- Macro: UDP_TO_AXI_LENGTH_CHECK_EN.
- Defined:
  - Udp_length is sampled at packet start.
  - A 16-bit byte counter counts accepted bytes in the packet.
  - On the last byte, if counter+1 != sampled length, Length_error pulses high for one cycle in the cycle after acceptance.
  - Data passes through unchanged; nothing is dropped.
  - The counter saturates at all-ones.
- Not defined:
  - Length_error port is absent.
  - Udp_length is unused; tie-off permitted.
  - No counter logic is built.

Decomposition:
- eth_pkg: reuse eth_udp_length_width; add udp_to_axi_word_t struct {data, keep, last} parameterised by width via localparam in the module.
- No sub-module: the packer, output register and length check stay flat in one module of roughly 150-250 lines.

Test Plan (AXI_DATA_WIDTH=32):
- Packet bytes 01..08, length 8, M_axis_ready=1 -> two words: 04030201 keep=F last=0, then 08070605 keep=F last=1; second word one cycle after byte 08.
- Packet bytes AA,BB,CC, length 3 -> one word 00CCBBAA keep=7 last=1. Packet 5 bytes -> second word keep=1 last=1.
- M_axis_ready=0 for 10 cycles mid-packet -> Udp_ready low while output full, M_axis_data/keep/last stable, no byte lost or duplicated; resume gives correct sequence.
- Random packets 1..1200 bytes, 80% random M_axis_ready, 10% upstream gaps -> unpacked output bytes equal input bytes per packet; last count equals packet count.
- Rst_n low for one cycle after 6 bytes of a 12-byte packet, then a fresh 4-byte packet 11,22,33,44 -> no partial word emitted; single word 44332211 keep=F last=1.
- With UDP_TO_AXI_LENGTH_CHECK_EN: 5-byte packet with Udp_length=6 -> one Length_error pulse one cycle after the last byte; matching length -> no pulse.
